// File: rtl/rail_pkg.sv
// Shared types and constants for the digit sequencer slice.
// Holds the sequencer state type, the digit type and the legal-digit limit.
// Helper functions size counters and qualify incoming digits.
package rail_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        MOVE   = 2'd2,
        STRIKE = 2'd3
    } seq_state_t;

    localparam int unsigned DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t MAX_DIGIT = 4'd9;

    // A digit is legal only inside 0..MAX_DIGIT; 10..15 are dropped at the queue.
    function automatic logic digit_legal(input digit_t d);
        return d <= MAX_DIGIT;
    endfunction

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_sequencer_if.sv
// Request queue and stepper-driver signals of the digit sequencer.
// master = requester/driver side, slave = the sequencer itself.
// Every slave output is a flop inside the sequencer.
interface digit_sequencer_if;
    import rail_pkg::*;

    logic   push;
    digit_t digit_in;
    logic   full;
    logic   empty;
    logic   reject;
    logic   position_reached;
    logic   drv_load;
    logic   drv_en;
    digit_t drv_digit;
    logic   busy;
    logic   done;
    logic   timeout;

    modport master (
        output push, digit_in, position_reached,
        input  full, empty, reject, drv_load, drv_en, drv_digit, busy, done, timeout
    );

    modport slave (
        input  push, digit_in, position_reached,
        output full, empty, reject, drv_load, drv_en, drv_digit, busy, done, timeout
    );

endinterface

// File: rtl/digit_fifo.sv
// Purpose: DEPTH-entry queue of 4-bit digits with range check on push.
// Latency: a pushed digit is visible at the head (empty=0) one cycle after the push.
// Backpressure: push dropped with a one-cycle reject when illegal or full without a pop.
module digit_fifo
    import rail_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  digit_t wr_data,
    input  logic   pop,
    output digit_t rd_data,
    output logic   full,
    output logic   empty,
    output logic   reject
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    digit_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_pop;
    logic          do_push;

    assign rd_data = mem[rd_ptr];

    // Pop needs a stored entry; a pop frees the slot a push into a full queue needs.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && digit_legal(wr_data) && (!full || do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers, occupancy and the registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            reject <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count  <= count_nxt;
            full   <= (count_nxt == FULL_CNT);
            empty  <= (count_nxt == '0);
            reject <= push && !do_push;
        end
    end

    // Storage needs no reset; only slots behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/digit_sequencer.sv
// Purpose: pops queued digits and walks each through load, move and strike on the driver.
// Latency: drv_load one cycle after the pop edge, drv_en the cycle after that.
// Backpressure: one digit in flight; the rest wait in the queue, overflow is rejected.
module digit_sequencer
    import rail_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int STRIKE_CYCLES  = 40000000
) (
    input  logic             clk,
    input  logic             reset,
    digit_sequencer_if.slave bus
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int SW = cnt_width(STRIKE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STRIKE_CYCLES - 1);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_cnt_nxt;
    logic [SW-1:0] stk_cnt;
    logic [SW-1:0] stk_cnt_nxt;

    logic   pop;
    logic   take;
    digit_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_reject;

    logic   drv_load_d, drv_en_d, busy_d, done_d, timeout_d;
    logic   drv_load_q, drv_en_q, busy_q, done_q, timeout_q;
    digit_t drv_digit_q;

    digit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.push),
        .wr_data (bus.digit_in),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .reject  (fifo_reject)
    );

    // The queue only pops while idle; take marks the edge a digit really leaves it.
    assign pop  = (state == IDLE);
    assign take = pop && !fifo_empty;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; position_reached wins over the last timeout cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = LOAD;
            LOAD:    state_nxt = MOVE;
            MOVE: begin
                if (bus.position_reached) begin
                    state_nxt = STRIKE;
                end else if (tmo_cnt == T_LAST) begin
                    state_nxt = IDLE;
                end
            end
            STRIKE:  if (stk_cnt == S_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters clear on entry to their state and saturate instead of wrapping.
    always_comb begin
        tmo_cnt_nxt = tmo_cnt;
        stk_cnt_nxt = stk_cnt;
        if (state_nxt == MOVE && state != MOVE) begin
            tmo_cnt_nxt = '0;
        end else if (state == MOVE && state_nxt == MOVE) begin
            tmo_cnt_nxt = (tmo_cnt == {TW{1'b1}}) ? tmo_cnt : tmo_cnt + 1'b1;
        end
        if (state_nxt == STRIKE && state != STRIKE) begin
            stk_cnt_nxt = '0;
        end else if (state == STRIKE && state_nxt == STRIKE) begin
            stk_cnt_nxt = (stk_cnt == {SW{1'b1}}) ? stk_cnt : stk_cnt + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            stk_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
            stk_cnt <= stk_cnt_nxt;
        end
    end

    // Output decode from the upcoming state so each flop lines up with that state.
    always_comb begin
        drv_load_d = (state_nxt == LOAD);
        drv_en_d   = (state_nxt == MOVE) || (state_nxt == STRIKE);
        busy_d     = (state_nxt != IDLE);
        done_d     = (state_nxt == STRIKE) && (stk_cnt_nxt == S_LAST);
        timeout_d  = (state == MOVE) && (state_nxt == IDLE);
    end

    // Output flops; reset drops drv_en at once without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drv_load_q  <= 1'b0;
            drv_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            drv_digit_q <= '0;
        end else begin
            drv_load_q <= drv_load_d;
            drv_en_q   <= drv_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            if (take) begin
                drv_digit_q <= head;
            end
        end
    end

    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.reject    = fifo_reject;
    assign bus.drv_load  = drv_load_q;
    assign bus.drv_en    = drv_en_q;
    assign bus.drv_digit = drv_digit_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Bench for digit_sequencer with short timing parameters.
// A queue/age reference model predicts every output each cycle; directed
// scenarios add literal cycle counts and digit orders on top.
module tb_digit_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 50;
    localparam int SC    = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    digit_sequencer_if bus();

    digit_sequencer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .STRIKE_CYCLES  (SC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic bound_check(input string name, input int n, input int limit);
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
        end
    endtask

    // ---------------- reference model ----------------
    // Job progress is an age (cycles since pop) plus the MOVE cycle at which
    // the target was hit; roles follow arithmetically from those two numbers.
    int         m_q[$];
    int         m_age = 0;
    int         m_hit = 0;
    int         m_pre;
    int         m_mv;
    int         m_s;
    bit         m_popped;
    logic [3:0] m_digit = 4'd0;

    logic       exp_full = 1'b0, exp_empty = 1'b1, exp_reject = 1'b0;
    logic       exp_load = 1'b0, exp_en = 1'b0, exp_busy = 1'b0;
    logic       exp_done = 1'b0, exp_timeout = 1'b0;
    logic [3:0] exp_digit = 4'd0;

    initial forever begin
        @(posedge clk or posedge reset);
        exp_timeout = 1'b0;
        exp_reject  = 1'b0;
        if (reset) begin
            m_q.delete();
            m_age   = 0;
            m_hit   = 0;
            m_digit = 4'd0;
        end else begin
            m_pre    = m_q.size();
            m_popped = 1'b0;
            if (m_age == 0) begin
                if (m_pre > 0) begin
                    m_digit  = 4'(m_q.pop_front());
                    m_popped = 1'b1;
                    m_age    = 1;
                    m_hit    = 0;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_hit == 0) begin
                m_mv = m_age - 1;
                if (bus.position_reached) begin
                    m_hit = m_mv;
                    m_age++;
                end else if (m_mv == TO) begin
                    m_age       = 0;
                    exp_timeout = 1'b1;
                end else begin
                    m_age++;
                end
            end else begin
                m_s = m_age - 1 - m_hit;
                if (m_s == SC) m_age = 0;
                else m_age++;
            end
            if (bus.push) begin
                if (bus.digit_in <= 4'd9 && (m_pre < DEPTH || m_popped)) m_q.push_back(int'(bus.digit_in));
                else exp_reject = 1'b1;
            end
        end
        exp_busy  = (m_age != 0);
        exp_load  = (m_age == 1);
        exp_en    = (m_age >= 2);
        exp_done  = (m_age >= 2) && (m_hit != 0) && ((m_age - 1 - m_hit) == SC);
        exp_digit = m_digit;
        exp_empty = (m_q.size() == 0);
        exp_full  = (m_q.size() == DEPTH);
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin
        check("cmp_full",      bus.full,      exp_full);
        check("cmp_empty",     bus.empty,     exp_empty);
        check("cmp_reject",    bus.reject,    exp_reject);
        check("cmp_drv_load",  bus.drv_load,  exp_load);
        check("cmp_drv_en",    bus.drv_en,    exp_en);
        check("cmp_drv_digit", bus.drv_digit, exp_digit);
        check("cmp_busy",      bus.busy,      exp_busy);
        check("cmp_done",      bus.done,      exp_done);
        check("cmp_timeout",   bus.timeout,   exp_timeout);
    end

    // ---------------- event monitor ----------------
    int n_load = 0, n_done = 0, n_tmo = 0, n_rej = 0, n_en = 0;
    int loaded[$];

    always @(negedge clk) begin
        if (bus.drv_load === 1'b1) begin
            n_load++;
            loaded.push_back(int'(bus.drv_digit));
        end
        if (bus.done === 1'b1)    n_done++;
        if (bus.timeout === 1'b1) n_tmo++;
        if (bus.reject === 1'b1)  n_rej++;
        if (bus.drv_en === 1'b1)  n_en++;
    end

    int b_load, b_done, b_tmo, b_rej, b_en;

    task automatic snap();
        #1;
        b_load = n_load;
        b_done = n_done;
        b_tmo  = n_tmo;
        b_rej  = n_rej;
        b_en   = n_en;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic push_digit(input int d);
        bus.push     = 1'b1;
        bus.digit_in = 4'(d);
        @(negedge clk);
        bus.push     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        bound_check(name, n, limit);
    endtask

    task automatic wait_en(input string name);
        int n;
        n = 0;
        while (bus.drv_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bound_check(name, n, 20);
    endtask

    // Pulse position_reached now and count falling edges until done appears.
    task automatic strike_now(input string name);
        int k;
        k = 0;
        bus.position_reached = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) bus.position_reached = 1'b0;
        end while (bus.done !== 1'b1 && k < 40);
        check(name, k, 10);
    endtask

    int exp_seq[6] = '{7, 1, 2, 3, 4, 9};

    initial begin
        int n;
        int idx;
        bus.push             = 1'b0;
        bus.digit_in         = 4'd0;
        bus.position_reached = 1'b0;

        // Reset values.
        #1 reset = 1'b1;
        #1;
        check("rst_empty",    bus.empty,     1);
        check("rst_full",     bus.full,      0);
        check("rst_busy",     bus.busy,      0);
        check("rst_drv_en",   bus.drv_en,    0);
        check("rst_drv_load", bus.drv_load,  0);
        check("rst_digit",    bus.drv_digit, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single request.
        snap();
        push_digit(4);
        wait_en("single_wait_en");
        repeat (5) @(negedge clk);
        strike_now("single_done_latency");
        wait_idle("single_idle", 40);
        #1;
        check("single_loads",   n_load - b_load, 1);
        check("single_digit",   loaded[loaded.size() - 1], 4);
        check("single_en_cyc",  n_en - b_en, 16);
        check("single_dones",   n_done - b_done, 1);
        check("single_tmo",     n_tmo - b_tmo, 0);
        check("single_busy",    bus.busy, 0);

        // Illegal digit.
        @(negedge clk);
        push_digit(12);
        check("illegal_reject", bus.reject, 1);
        check("illegal_empty",  bus.empty, 1);
        @(negedge clk);
        check("illegal_reject_end", bus.reject, 0);

        // Overflow, timeout chain and push-while-full in the pop cycle.
        snap();
        push_digit(7);
        n = 0;
        while (bus.drv_load !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bound_check("ovf_wait_load", n, 10);
        for (int i = 1; i <= 5; i++) push_digit(i);
        check("ovf_reject", bus.reject, 1);
        check("ovf_full",   bus.full, 1);
        n = 0;
        while (bus.timeout !== 1'b1 && n < 120) begin
            @(negedge clk);
            n++;
        end
        bound_check("tmo_wait", n, 120);
        check("tmo_drv_en_low", bus.drv_en, 0);
        push_digit(9);
        check("simul_no_reject", bus.reject, 0);
        check("simul_full",      bus.full, 1);
        check("simul_next_load", bus.drv_load, 1);
        check("simul_next_dig",  bus.drv_digit, 1);
        wait_idle("ovf_idle", 800);
        #1;
        check("ovf_rejects",  n_rej - b_rej, 1);
        check("ovf_timeouts", n_tmo - b_tmo, 6);
        check("ovf_loads",    n_load - b_load, 6);
        check("ovf_en_cyc",   n_en - b_en, 300);
        for (int i = 0; i < 6; i++) begin
            idx = b_load + i;
            check("ovf_order", (idx < loaded.size()) ? loaded[idx] : 15, exp_seq[i]);
        end

        // position_reached in the final timeout cycle.
        @(negedge clk);
        snap();
        push_digit(3);
        wait_en("late_wait_en");
        repeat (TO - 1) @(negedge clk);
        strike_now("late_done_latency");
        wait_idle("late_idle", 40);
        #1;
        check("late_tmo",    n_tmo - b_tmo, 0);
        check("late_dones",  n_done - b_done, 1);
        check("late_en_cyc", n_en - b_en, 60);

        // Reset in the middle of MOVE with two digits queued.
        @(negedge clk);
        push_digit(5);
        push_digit(6);
        push_digit(8);
        wait_en("mid_wait_en");
        check("mid_pre_empty", bus.empty, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_drv_en",  bus.drv_en, 0);
        check("mid_busy",    bus.busy, 0);
        check("mid_empty",   bus.empty, 1);
        check("mid_full",    bus.full, 0);
        check("mid_digit",   bus.drv_digit, 0);
        check("mid_load",    bus.drv_load, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_after_empty", bus.empty, 1);
        check("mid_after_busy",  bus.busy, 0);

        // Randomised traffic against the model.
        repeat (3000) begin
            bus.push = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) bus.digit_in = 4'($urandom_range(10, 15));
            else bus.digit_in = 4'($urandom_range(0, 9));
            bus.position_reached = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        bus.push             = 1'b0;
        bus.position_reached = 1'b0;
        wait_idle("rand_drain", 2000);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
